// File: rtl/row_fetch_sequencer.sv
// Display line fetcher in front of the SDRAM row controller: fetches one row into a
// back buffer, then serves pixels from a front buffer while the next row is fetched.
module row_fetch_sequencer #(
   parameter int unsigned LINE_BITS = 1696,
   parameter int unsigned PIX_BITS  = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 CLK,
   input  logic                 Reset_N,
   input  logic                 LineReq,
   input  logic [8:0]           LineNum,
   input  logic [1:0]           FrameSel,
   input  logic                 Swap,
   input  logic [8:0]           PixX,
   output logic [PIX_BITS-1:0]  Pixel,
   output logic                 LineReady,
   output logic                 Busy,
   output logic                 ReqDropped,
   output logic                 Underrun,
   output logic                 Error,
   output logic [8:0]           MemRowAddress,
   output logic [1:0]           MemBankAddress,
   output logic                 MemWrite,
   output logic                 MemReset,
   output logic [LINE_BITS-1:0] MemIn,
   input  logic                 MemDone,
   input  logic [LINE_BITS-1:0] MemOut
);
   localparam int unsigned PIXELS = LINE_BITS / PIX_BITS;
   localparam int unsigned BUF_W  = PIXELS * PIX_BITS;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
   // Counter starts one cycle after ISSUE, so the abort fires at TIMEOUT-2.
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 2);
   localparam logic [9:0]       PIX_LIMIT = 10'(PIXELS);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_LOW,
      WAIT_HIGH,
      CAPTURE
   } state_t;

   state_t                            state;
   logic [CNT_W-1:0]                  cnt;
   logic [PIXELS-1:0][PIX_BITS-1:0]   front;
   logic [PIXELS-1:0][PIX_BITS-1:0]   back;

   // The controller is only ever read.
   assign MemWrite = 1'b0;
   assign MemIn    = '0;

   always_ff @(posedge CLK) begin
      if (!Reset_N) begin
         state          <= IDLE;
         cnt            <= '0;
         front          <= '0;
         back           <= '0;
         Pixel          <= '0;
         LineReady      <= 1'b0;
         Busy           <= 1'b0;
         ReqDropped     <= 1'b0;
         Underrun       <= 1'b0;
         Error          <= 1'b0;
         MemRowAddress  <= '0;
         MemBankAddress <= '0;
         MemReset       <= 1'b0;
      end else begin
         MemReset   <= 1'b0;
         ReqDropped <= 1'b0;
         Underrun   <= 1'b0;
         Error      <= 1'b0;

         // Swap acts on the current LineReady; a capture this cycle overrides it below.
         if (Swap) begin
            if (LineReady) begin
               front     <= back;
               LineReady <= 1'b0;
            end else begin
               Underrun <= 1'b1;
            end
         end

         if (LineReq && (state != IDLE)) begin
            ReqDropped <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (LineReq) begin
                  MemRowAddress  <= LineNum;
                  MemBankAddress <= FrameSel;
                  LineReady      <= 1'b0;
                  Busy           <= 1'b1;
                  MemReset       <= 1'b1;
                  cnt            <= '0;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
               // Done is trusted only after it has been seen low once.
               if ((state == WAIT_HIGH) && MemDone) begin
                  state <= CAPTURE;
               end else if (cnt == CNT_LAST) begin
                  Error     <= 1'b1;
                  LineReady <= 1'b0;
                  Busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (!MemDone) begin
                     state <= WAIT_HIGH;
                  end
               end
            end
            CAPTURE: begin
               back      <= BUF_W'(MemOut);
               LineReady <= 1'b1;
               Busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         Pixel <= ({1'b0, PixX} < PIX_LIMIT) ? front[PixX] : '0;
      end
   end

endmodule
